mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load formatting, write-back select, single-shot write enable and retire counter.
// Optional forwarding port to EX is enabled by defining MEM_WB_FWD_EN; otherwise fwd_* are tied low.
module mem_wb_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  mem_rd_data,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [RADDR-1:0] rd_addr,
  input  logic [2:0]       funct3,
  input  logic [1:0]       wb_sel,
  input  logic             reg_write,
  output logic             wb_valid,
  output logic [RADDR-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_we,
  output logic             load_err,
  output logic [63:0]      instret,
  output logic             fwd_valid,
  output logic [RADDR-1:0] fwd_rd,
  output logic [XLEN-1:0]  fwd_data
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  logic             valid_q, valid_d;
  logic             fresh_q, fresh_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             rw_q, rw_d;
  logic             lerr_q, lerr_d;
  logic [63:0]      instret_q, instret_d;

  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  fmt_data;
  logic             retire;

  assign in_ready = !stall;
  assign retire   = valid_q && fresh_q;

  // Reserved encoding 111 passes the raw word through, same as the full-width load.
  always_comb begin
    load_val = mem_rd_data;
    case (funct3)
      3'b000:  load_val = XLEN'($signed(mem_rd_data[7:0]));
      3'b001:  load_val = XLEN'($signed(mem_rd_data[15:0]));
      3'b010:  load_val = XLEN'($signed(mem_rd_data[31:0]));
      3'b100:  load_val = XLEN'(mem_rd_data[7:0]);
      3'b101:  load_val = XLEN'(mem_rd_data[15:0]);
      3'b110:  load_val = XLEN'(mem_rd_data[31:0]);
      default: load_val = mem_rd_data;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_ALU:  fmt_data = alu_result;
      WB_LOAD: fmt_data = load_val;
      WB_LINK: fmt_data = pc_plus4;
      default: fmt_data = '0;
    endcase
  end

  // The retire count uses the pre-edge state, so a stall+flush cycle still retires a fresh instruction.
  always_comb begin
    valid_d   = valid_q;
    fresh_d   = fresh_q;
    rd_d      = rd_q;
    data_d    = data_q;
    rw_d      = rw_q;
    lerr_d    = 1'b0;
    instret_d = instret_q + 64'(retire);
    if (flush) begin
      valid_d = 1'b0;
      fresh_d = 1'b0;
    end else if (stall) begin
      fresh_d = 1'b0;
    end else if (in_valid) begin
      valid_d = 1'b1;
      fresh_d = 1'b1;
      rd_d    = rd_addr;
      data_d  = fmt_data;
      rw_d    = reg_write;
      lerr_d  = (wb_sel == WB_LOAD) && (funct3 == 3'b111);
    end else begin
      valid_d = 1'b0;
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      lerr_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      fresh_q   <= fresh_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      lerr_q    <= lerr_d;
      instret_q <= instret_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign wb_we    = valid_q && fresh_q && rw_q && (rd_q != '0);
  assign load_err = lerr_q;
  assign instret  = instret_q;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = valid_q && rw_q && (rd_q != '0);
  assign fwd_rd    = rd_q;
  assign fwd_data  = data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule
